// File: rtl/rv32i_lsu_pkg.sv
// rv32i_lsu_pkg: state encodings and RV32I funct3 codes shared by the load/store path
package rv32i_lsu_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_e;
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;
  function automatic logic load_f3_ok(input logic [2:0] f3);
    return f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU;
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/half of a bus word and sign/zero-extends it
module load_align
  import rv32i_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  always_comb begin
    byte_sel = offset_i[1] ? (offset_i[0] ? rdata_i[31:24] : rdata_i[23:16])
                           : (offset_i[0] ? rdata_i[15:8]  : rdata_i[7:0]);
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o   = funct3_i == F3_LB  ? {{24{byte_sel[7]}}, byte_sel} :
               funct3_i == F3_LBU ? {24'b0, byte_sel} :
               funct3_i == F3_LH  ? {{16{half_sel[15]}}, half_sel} :
               funct3_i == F3_LHU ? {16'b0, half_sel} : rdata_i;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory stage, valid/ready bus handshake, core stall.
// Define MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning them.
module load_store_unit
  import rv32i_lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] load_data,
  output logic            err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  state_e          state_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [CW-1:0]   cnt_q;
  logic            mem_req_q, mem_we_q, done_q, err_q;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [XLEN-1:0] addr_q, wdata_q, wdata_d, load_data_q;
  logic [31:0]     ld_word;
  logic            bad_d, misalign_d, tmo;
  load_align u_align (
    .rdata_i (mem_rdata),
    .offset_i(off_q),
    .funct3_i(f3_q),
    .data_o  (ld_word)
  );
  always_comb begin
`ifdef MISALIGN_TRAP_EN
    misalign_d = (funct3[1:0] == 2'd1 && addr[0]) || (funct3[1:0] == 2'd2 && addr[1:0] != 2'b00);
`else
    misalign_d = 1'b0;
`endif
    bad_d   = (mem_read && mem_write) || (mem_read && !load_f3_ok(funct3)) ||
              (mem_write && funct3 > F3_SW) || misalign_d;
    wstrb_d = !mem_write        ? 4'b0000 :
              funct3 == F3_SB   ? 4'b0001 << addr[1:0] :
              funct3 == F3_SH   ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_d = funct3 == F3_SB ? {4{wdata[7:0]}} :
              funct3 == F3_SH ? {2{wdata[15:0]}} : wdata;
    tmo     = TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST;
  end
  // done/err are one-cycle pulses; bus fields hold their last value after REQ
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      f3_q        <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wstrb_q     <= 4'b0000;
      addr_q      <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (req_valid && (mem_read || mem_write)) begin
          if (bad_d) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            load_data_q <= '0;
          end else begin
            state_q   <= REQ;
            mem_req_q <= 1'b1;
            mem_we_q  <= mem_write;
            addr_q    <= {addr[XLEN-1:2], 2'b00};
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
            f3_q      <= funct3;
            off_q     <= addr[1:0];
            cnt_q     <= '0;
          end
        end
        REQ: if (mem_ready) begin
          state_q     <= DONE;
          mem_req_q   <= 1'b0;
          done_q      <= 1'b1;
          load_data_q <= mem_we_q ? '0 : ld_word;
        end else if (tmo) begin
          state_q     <= DONE;
          mem_req_q   <= 1'b0;
          done_q      <= 1'b1;
          err_q       <= 1'b1;
          load_data_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign stall     = req_valid && state_q != DONE;
  assign done      = done_q;
  assign err       = err_q;
  assign load_data = load_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;
endmodule
